// File: rtl/rv_decode_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv_decode_pipe: RV decode stage, regfile, WB bypass, load-use bubble |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rv_decode_pipe #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_id_valid,
  input  logic [31:0]     if_id_ir,
  input  logic [XLEN-1:0] if_id_pc,
  output logic            if_id_ready,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            id_ex_valid,
  output logic [31:0]     id_ex_ir,
  output logic [XLEN-1:0] id_ex_pc,
  output logic [XLEN-1:0] id_ex_rs1_val,
  output logic [XLEN-1:0] id_ex_rs2_val,
  output logic [XLEN-1:0] id_ex_imm,
  output logic [4:0]      id_ex_rd,
  output logic [2:0]      id_ex_funct3,
  output logic [6:0]      id_ex_funct7,
  output logic            hazard_o
);

  localparam int         c_aw       = $clog2(NREGS);
  localparam logic [5:0] c_nregs    = 6'(NREGS);
  localparam logic [6:0] c_op_opimm = 7'b0010011;
  localparam logic [6:0] c_op_load  = 7'b0000011;
  localparam logic [6:0] c_op_jalr  = 7'b1100111;
  localparam logic [6:0] c_op_store = 7'b0100011;
  localparam logic [6:0] c_op_branch= 7'b1100011;
  localparam logic [6:0] c_op_lui   = 7'b0110111;
  localparam logic [6:0] c_op_auipc = 7'b0010111;
  localparam logic [6:0] c_op_jal   = 7'b1101111;
  localparam logic [6:0] c_op_reg   = 7'b0110011;

  logic [XLEN-1:0] r_rf [NREGS];

  logic            r_valid;
  logic [31:0]     r_ir;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rs1_val;
  logic [XLEN-1:0] r_rs2_val;
  logic [XLEN-1:0] r_imm;
  logic [4:0]      r_rd;
  logic [2:0]      r_funct3;
  logic [6:0]      r_funct7;

  logic [6:0]      w_op;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic            w_wb_ok;
  logic            w_uses_rs2;
  logic            w_load_use;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;

  assign w_op    = if_id_ir[6:0];
  assign w_rs1   = if_id_ir[19:15];
  assign w_rs2   = if_id_ir[24:20];
  assign w_wb_ok = wb_we && (wb_rd != 5'd0) && ({1'b0, wb_rd} < c_nregs);

  // Out-of-range indices read as zero; a matching WB write is forwarded when enabled.
  function automatic logic [XLEN-1:0] f_read(input logic [4:0] idx);
    if (idx == 5'd0 || {1'b0, idx} >= c_nregs)
      f_read = '0;
    else if (BYPASS != 0 && w_wb_ok && wb_rd == idx)
      f_read = wb_data;
    else
      f_read = r_rf[idx[c_aw-1:0]];
  endfunction

  assign w_rs1_val = f_read(w_rs1);
  assign w_rs2_val = f_read(w_rs2);

  always_comb begin
    w_imm32 = '0;
    case (w_op)
      c_op_opimm, c_op_load, c_op_jalr:
        w_imm32 = {{20{if_id_ir[31]}}, if_id_ir[31:20]};
      c_op_store:
        w_imm32 = {{20{if_id_ir[31]}}, if_id_ir[31:25], if_id_ir[11:7]};
      c_op_branch:
        w_imm32 = {{19{if_id_ir[31]}}, if_id_ir[31], if_id_ir[7],
                   if_id_ir[30:25], if_id_ir[11:8], 1'b0};
      c_op_lui, c_op_auipc:
        w_imm32 = {if_id_ir[31:12], 12'b0};
      c_op_jal:
        w_imm32 = {{11{if_id_ir[31]}}, if_id_ir[31], if_id_ir[19:12],
                   if_id_ir[20], if_id_ir[30:21], 1'b0};
      default:
        w_imm32 = '0;
    endcase
  end

  assign w_imm = XLEN'($signed(w_imm32));

  assign w_uses_rs2 = (w_op == c_op_reg) || (w_op == c_op_store) || (w_op == c_op_branch);
  assign w_load_use = r_valid && (r_ir[6:0] == c_op_load) && (r_rd != 5'd0) && if_id_valid &&
                      ((r_rd == w_rs1) || (w_uses_rs2 && (r_rd == w_rs2)));

  assign hazard_o    = w_load_use && !stall_i;
  assign if_id_ready = flush_i || (!stall_i && !w_load_use);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
    end else if (w_wb_ok) begin
      r_rf[wb_rd[c_aw-1:0]] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid   <= 1'b0;
      r_ir      <= '0;
      r_pc      <= '0;
      r_rs1_val <= '0;
      r_rs2_val <= '0;
      r_imm     <= '0;
      r_rd      <= '0;
      r_funct3  <= '0;
      r_funct7  <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (!stall_i) begin
      if (w_load_use) begin
        r_valid <= 1'b0;
        r_ir    <= '0;
      end else begin
        r_valid   <= if_id_valid;
        r_ir      <= if_id_ir;
        r_pc      <= if_id_pc;
        r_rs1_val <= w_rs1_val;
        r_rs2_val <= w_rs2_val;
        r_imm     <= w_imm;
        r_rd      <= if_id_ir[11:7];
        r_funct3  <= if_id_ir[14:12];
        r_funct7  <= if_id_ir[31:25];
      end
    end
  end

  assign id_ex_valid   = r_valid;
  assign id_ex_ir      = r_ir;
  assign id_ex_pc      = r_pc;
  assign id_ex_rs1_val = r_rs1_val;
  assign id_ex_rs2_val = r_rs2_val;
  assign id_ex_imm     = r_imm;
  assign id_ex_rd      = r_rd;
  assign id_ex_funct3  = r_funct3;
  assign id_ex_funct7  = r_funct7;

endmodule
`default_nettype wire

// File: tb/tb_rv_decode_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rv_decode_pipe: scoreboard bench, two configurations side by side |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_rv_decode_pipe;

  typedef struct packed {
    logic        cc;
    logic        haz;
    logic        rdy;
    logic        valid;
    logic        kir;
    logic        krest;
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_id_valid = 1'b0;
  logic [31:0] if_id_ir = '0;
  logic [31:0] if_id_pc = '0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;

  logic        d_ready[2];
  logic        d_haz[2];
  logic        d_valid[2];
  logic [31:0] d_ir[2];
  logic [31:0] d_pc[2];
  logic [31:0] d_rs1[2];
  logic [31:0] d_rs2[2];
  logic [31:0] d_imm[2];
  logic [4:0]  d_rd[2];
  logic [2:0]  d_f3[2];
  logic [6:0]  d_f7[2];

  int total = 0;
  int bad   = 0;

  exp_t        sb0[$];
  exp_t        sb1[$];
  exp_t        ms[2];
  logic [31:0] m_rf[2][32];
  logic        m_init = 1'b0;
  logic        m_last_rdy = 1'b1;

  always #5 clk = ~clk;

  rv_decode_pipe #(.XLEN(32), .NREGS(32), .BYPASS(1)) u_dut0 (
    .clk(clk), .rst(rst), .if_id_valid(if_id_valid), .if_id_ir(if_id_ir), .if_id_pc(if_id_pc),
    .if_id_ready(d_ready[0]), .stall_i(stall_i), .flush_i(flush_i), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_data(wb_data), .id_ex_valid(d_valid[0]), .id_ex_ir(d_ir[0]),
    .id_ex_pc(d_pc[0]), .id_ex_rs1_val(d_rs1[0]), .id_ex_rs2_val(d_rs2[0]),
    .id_ex_imm(d_imm[0]), .id_ex_rd(d_rd[0]), .id_ex_funct3(d_f3[0]),
    .id_ex_funct7(d_f7[0]), .hazard_o(d_haz[0])
  );

  rv_decode_pipe #(.XLEN(32), .NREGS(16), .BYPASS(0)) u_dut1 (
    .clk(clk), .rst(rst), .if_id_valid(if_id_valid), .if_id_ir(if_id_ir), .if_id_pc(if_id_pc),
    .if_id_ready(d_ready[1]), .stall_i(stall_i), .flush_i(flush_i), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_data(wb_data), .id_ex_valid(d_valid[1]), .id_ex_ir(d_ir[1]),
    .id_ex_pc(d_pc[1]), .id_ex_rs1_val(d_rs1[1]), .id_ex_rs2_val(d_rs2[1]),
    .id_ex_imm(d_imm[1]), .id_ex_rd(d_rd[1]), .id_ex_funct3(d_f3[1]),
    .id_ex_funct7(d_f7[1]), .hazard_o(d_haz[1])
  );

  function automatic int cfg_nregs(input int k);
    return (k == 0) ? 32 : 16;
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    logic [31:0] v;
    case (i[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: v = 32'($signed(i[31:20]));
      7'b0100011: v = 32'($signed({i[31:25], i[11:7]}));
      7'b1100011: v = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      7'b0110111, 7'b0010111: v = {i[31:12], 12'h000};
      7'b1101111: v = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] ref_read(input int k, input logic [4:0] idx);
    if (idx == 0 || int'(idx) >= cfg_nregs(k)) return 32'h0;
    if (k == 0 && wb_we && wb_rd == idx) return wb_data;
    return m_rf[k][idx];
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rd, rs1, rs2);
    return {7'h00, rs2, rs1, 3'h0, rd, 7'h33};
  endfunction

  function automatic logic [31:0] itype(input logic [6:0] op, input logic [4:0] rd, rs1,
                                        input logic [11:0] imm, input logic [2:0] f3);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [4:0] rnd_reg();
    return ($urandom_range(0, 9) < 8) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [6:0] ops[10];
    logic [31:0] i;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h03};
    i = $urandom;
    if ($urandom_range(0, 9) != 0) i[6:0] = ops[$urandom_range(0, 9)];
    i[11:7]  = rnd_reg();
    i[19:15] = rnd_reg();
    i[24:20] = rnd_reg();
    return i;
  endfunction

  // Drive one cycle of inputs, then predict the response of both configurations.
  task automatic step(input logic r, v, input logic [31:0] i, p, input logic s, f, w,
                      input logic [4:0] d, input logic [31:0] dat);
    logic raw, r2use;
    logic [4:0] rs1, rs2;
    logic [31:0] v1, v2;
    exp_t e;
    @(negedge clk);
    rst = r; if_id_valid = v; if_id_ir = i; if_id_pc = p;
    stall_i = s; flush_i = f; wb_we = w; wb_rd = d; wb_data = dat;
    #1;
    rs1 = i[19:15];
    rs2 = i[24:20];
    r2use = (i[6:0] == 7'h33) || (i[6:0] == 7'h23) || (i[6:0] == 7'h63);
    for (int k = 0; k < 2; k++) begin
      raw = ms[k].valid && ms[k].ir[6:0] == 7'h03 && ms[k].rd != 0 && v &&
            (ms[k].rd == rs1 || (r2use && ms[k].rd == rs2));
      v1 = ref_read(k, rs1);
      v2 = ref_read(k, rs2);
      e.haz = raw && !s;
      e.rdy = f || (!s && !raw);
      e.cc  = m_init;
      if (!r) begin
        ms[k] = '0;
        ms[k].kir = 1'b1;
        ms[k].krest = 1'b1;
        for (int j = 0; j < 32; j++) m_rf[k][j] = 32'h0;
      end else begin
        if (w && d != 0 && int'(d) < cfg_nregs(k)) m_rf[k][d] = dat;
        if (f) begin
          ms[k].valid = 1'b0; ms[k].kir = 1'b0; ms[k].krest = 1'b0;
        end else if (!s) begin
          if (raw) begin
            ms[k].valid = 1'b0; ms[k].ir = 32'h0; ms[k].kir = 1'b1; ms[k].krest = 1'b0;
          end else begin
            ms[k].valid = v; ms[k].ir = i; ms[k].pc = p; ms[k].rs1 = v1; ms[k].rs2 = v2;
            ms[k].imm = ref_imm(i); ms[k].rd = i[11:7]; ms[k].f3 = i[14:12];
            ms[k].f7 = i[31:25]; ms[k].kir = 1'b1; ms[k].krest = 1'b1;
          end
        end
      end
      {e.valid, e.kir, e.krest, e.ir, e.pc, e.rs1, e.rs2, e.imm, e.rd, e.f3, e.f7} =
        {ms[k].valid, ms[k].kir, ms[k].krest, ms[k].ir, ms[k].pc, ms[k].rs1, ms[k].rs2,
         ms[k].imm, ms[k].rd, ms[k].f3, ms[k].f7};
      if (k == 0) begin
        sb0.push_back(e);
        m_last_rdy = e.rdy;
      end else begin
        sb1.push_back(e);
      end
    end
    if (!r) m_init = 1'b1;
  endtask

  task automatic chk(input string n, input int k, input logic [31:0] a, e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s dut%0d @%0t: got %h expected %h", n, k, $time, a, e);
    end
  endtask

  // Monitor: comb outputs sampled mid-low-phase, registered outputs just after the edge.
  initial begin
    logic a_haz[2], a_rdy[2];
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      for (int k = 0; k < 2; k++) begin
        a_haz[k] = d_haz[k];
        a_rdy[k] = d_ready[k];
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if ((k == 0 && sb0.size() != 0) || (k == 1 && sb1.size() != 0)) begin
          e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
          if (e.cc) begin
            chk("hazard_o", k, 32'(a_haz[k]), 32'(e.haz));
            chk("if_id_ready", k, 32'(a_rdy[k]), 32'(e.rdy));
          end
          chk("id_ex_valid", k, 32'(d_valid[k]), 32'(e.valid));
          if (e.kir) chk("id_ex_ir", k, d_ir[k], e.ir);
          if (e.krest) begin
            chk("id_ex_pc", k, d_pc[k], e.pc);
            chk("id_ex_rs1_val", k, d_rs1[k], e.rs1);
            chk("id_ex_rs2_val", k, d_rs2[k], e.rs2);
            chk("id_ex_imm", k, d_imm[k], e.imm);
            chk("id_ex_rd", k, 32'(d_rd[k]), 32'(e.rd));
            chk("id_ex_funct3", k, 32'(d_f3[k]), 32'(e.f3));
            chk("id_ex_funct7", k, 32'(d_f7[k]), 32'(e.f7));
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] h_ir, h_pc;
    logic h_v;
    ms[0] = '0;
    ms[1] = '0;
    for (int j = 0; j < 32; j++) begin
      m_rf[0][j] = 32'h0;
      m_rf[1][j] = 32'h0;
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
    step(1, 0, 0, 0, 0, 0, 1, 5'd4, 32'h00000044);
    step(1, 1, rtype(1, 5, 0), 32'h100, 0, 0, 0, 0, 0);
    step(1, 1, rtype(2, 0, 0), 32'h104, 0, 0, 1, 5'd0, 32'h1234);
    step(1, 1, rtype(3, 20, 4), 32'h108, 0, 0, 1, 5'd20, 32'h55);
    step(1, 1, rtype(5, 20, 4), 32'h10c, 0, 0, 0, 0, 0);
    step(1, 1, itype(7'h13, 8, 7, 12'hFFF, 3'h0), 32'h110, 0, 0, 1, 5'd7, 32'hA5A5A5A5);
    step(1, 1, itype(7'h03, 3, 2, 12'h000, 3'h2), 32'h114, 0, 0, 0, 0, 0);
    step(1, 1, rtype(4, 3, 1), 32'h118, 0, 0, 0, 0, 0);
    step(1, 1, rtype(4, 3, 1), 32'h118, 0, 0, 0, 0, 0);
    step(1, 1, rtype(10, 9, 0), 32'h11c, 1, 0, 0, 0, 0);
    step(1, 1, rtype(10, 9, 0), 32'h11c, 1, 0, 1, 5'd9, 32'h99990001);
    step(1, 1, rtype(10, 9, 0), 32'h11c, 1, 0, 0, 0, 0);
    step(1, 1, rtype(10, 9, 0), 32'h11c, 0, 0, 0, 0, 0);
    step(1, 1, rtype(11, 1, 2), 32'h120, 1, 1, 0, 0, 0);
    step(1, 1, itype(7'h03, 3, 2, 12'h004, 3'h2), 32'h124, 0, 0, 0, 0, 0);
    step(0, 1, rtype(4, 3, 1), 32'h128, 0, 0, 1, 5'd6, 32'h6);
    step(1, 1, rtype(4, 3, 1), 32'h128, 0, 0, 0, 0, 0);

    h_ir = 32'h0; h_pc = 32'h0; h_v = 1'b0;
    for (int n = 0; n < 800; n++) begin
      if (m_last_rdy) begin
        h_ir = rnd_instr();
        h_pc = $urandom;
        h_v  = ($urandom_range(0, 99) < 85);
      end
      step(($urandom_range(0, 99) >= 2), h_v, h_ir, h_pc,
           ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 8),
           ($urandom_range(0, 1) == 1), rnd_reg(), $urandom);
    end

    repeat (3) @(negedge clk);
    total++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0", sb0.size(), sb1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
